// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundles every non-clock/reset signal of the multi-cycle control sequencer.
//
// Handshake rules (instruction and data memory): the controller raises a
// request (imem_req / dmem_req) and holds it high, unchanged, until it samples
// the matching ready (imem_ready / dmem_ready) high on a rising clock edge.
// Ready in the first request cycle is a zero-wait-state access. Ready seen
// while the matching request is low carries no meaning and is ignored.
//
// Modports:
//   master - the controller: consumes decode/flag/ready inputs, drives
//            datapath controls, requests and status.
//   slave  - the environment (decoder, datapath, memories).
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    // Inputs to the controller
    logic [31:0] inst_onehot;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    // Datapath controls and memory requests
    logic        imem_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic        alu_asel;
    logic        alu_bsel;
    logic        ext_sign;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [1:0]  wd_sel;
    logic        dmem_req;
    logic        dmem_we;
    // Status
    logic [2:0]  state;
    logic        illegal;
    logic        timeout;
    logic [31:0] retired;

    modport master (
        input  inst_onehot, zero, imem_ready, dmem_ready,
        output imem_req, ir_we, pc_we, pc_sel, alu_op, alu_asel, alu_bsel,
               ext_sign, rf_we, rf_wsel, wd_sel, dmem_req, dmem_we,
               state, illegal, timeout, retired
    );

    modport slave (
        output inst_onehot, zero, imem_ready, dmem_ready,
        input  imem_req, ir_we, pc_we, pc_sel, alu_op, alu_asel, alu_bsel,
               ext_sign, rf_we, rf_wsel, wd_sel, dmem_req, dmem_we,
               state, illegal, timeout, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control sequencer: steps each one-hot decoded instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the PC, IR, register
// file, ALU, extender and data-memory controls. Memory waits are bounded by
// WAIT_LIMIT; an illegal instruction or an expired wait parks the FSM in HALT.
//
// Parameters:
//   WAIT_LIMIT - wait cycles allowed on imem_ready/dmem_ready before timeout
//   CNT_W      - wait counter width, 2**CNT_W must exceed WAIT_LIMIT
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous, active-high reset
//   bus - multicycle_ctrl_if.master (decode input, flags, controls, status)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    // Counter value at which one more idle wait cycle reaches WAIT_LIMIT.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [30:0]      inst_q,     inst_d;
    logic             illegal_q,  illegal_d;
    logic             timeout_q,  timeout_d;
    logic [31:0]      retired_q,  retired_d;

    // Combinational outputs
    logic       imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we;
    logic [1:0] pc_sel, rf_wsel, wd_sel;
    logic [3:0] alu_op;
    logic       alu_asel, alu_bsel, ext_sign;

    // Decode of the latched instruction
    logic       is_jr, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic       is_rtype, is_shamt, is_imm_b, is_zext;
    logic       inst_legal;
    logic [3:0] alu_op_dec;

    assign is_jr    = inst_q[16];
    assign is_lw    = inst_q[22];
    assign is_sw    = inst_q[23];
    assign is_beq   = inst_q[24];
    assign is_bne   = inst_q[25];
    assign is_j     = inst_q[29];
    assign is_jal   = inst_q[30];
    assign is_rtype = |inst_q[15:0];
    assign is_shamt = |inst_q[12:10];
    assign is_imm_b = (|inst_q[23:17]) | (|inst_q[28:26]);
    assign is_zext  = (|inst_q[21:19]) | inst_q[28];

    // Exactly one of bits 0..30 set. An X on the input makes this condition
    // unknown, which the if in DECODE treats as false, so X also halts.
    assign inst_legal = (bus.inst_onehot != 32'd0)
                     && ((bus.inst_onehot & (bus.inst_onehot - 32'd1)) == 32'd0)
                     && !bus.inst_onehot[31];

    // One-hot input, so the conditions are mutually exclusive; anything not
    // listed (addu, addiu, lw, sw, jumps) falls back to ADDU.
    always_comb begin
        alu_op_dec = 4'd0;
        if (inst_q[0]  | inst_q[17])              alu_op_dec = 4'd1;
        if (inst_q[2]  | inst_q[24] | inst_q[25]) alu_op_dec = 4'd2;
        if (inst_q[3])                            alu_op_dec = 4'd3;
        if (inst_q[4]  | inst_q[19])              alu_op_dec = 4'd4;
        if (inst_q[5]  | inst_q[20])              alu_op_dec = 4'd5;
        if (inst_q[6]  | inst_q[21])              alu_op_dec = 4'd6;
        if (inst_q[7])                            alu_op_dec = 4'd7;
        if (inst_q[8]  | inst_q[26])              alu_op_dec = 4'd8;
        if (inst_q[9]  | inst_q[27])              alu_op_dec = 4'd9;
        if (inst_q[10] | inst_q[13])              alu_op_dec = 4'd10;
        if (inst_q[11] | inst_q[14])              alu_op_dec = 4'd11;
        if (inst_q[12] | inst_q[15])              alu_op_dec = 4'd12;
        if (inst_q[28])                           alu_op_dec = 4'd13;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        inst_d     = inst_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        rf_we      = 1'b0;
        rf_wsel    = 2'd0;
        wd_sel     = 2'd0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = 4'd0;
        alu_asel   = 1'b0;
        alu_bsel   = 1'b0;
        ext_sign   = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (inst_legal) begin
                    inst_d  = bus.inst_onehot[30:0];
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                if (is_beq | is_bne) begin
                    pc_we   = 1'b1;
                    pc_sel  = ((is_beq & bus.zero) | (is_bne & ~bus.zero)) ? 2'd1 : 2'd0;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    pc_sel  = 2'd3;
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    // Link write and jump share the single EXEC cycle.
                    pc_we   = 1'b1;
                    pc_sel  = 2'd2;
                    rf_we   = 1'b1;
                    rf_wsel = 2'd2;
                    wd_sel  = 2'd2;
                    state_d = S_FETCH;
                end else if (is_lw | is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (bus.dmem_ready) begin
                    if (is_sw) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                rf_wsel = is_rtype ? 2'd0 : 2'd1;
                wd_sel  = is_lw ? 2'd1 : 2'd0;
                state_d = S_FETCH;
            end
            default: begin
                // HALT (and the unused codes) absorb until reset.
                state_d = state_q;
            end
        endcase

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end

        // ALU and extender controls stay stable for the whole EXEC..WB span.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_op   = alu_op_dec;
            alu_asel = is_shamt;
            alu_bsel = is_imm_b;
            ext_sign = ~is_zext;
        end

        // Reset silences every control immediately, before the flops clear.
        if (rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 2'd0;
            rf_we    = 1'b0;
            rf_wsel  = 2'd0;
            wd_sel   = 2'd0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            alu_op   = 4'd0;
            alu_asel = 1'b0;
            alu_bsel = 1'b0;
            ext_sign = 1'b0;
        end

        retired_d = pc_we ? (retired_q + 32'd1) : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            inst_q     <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            inst_q     <= inst_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            retired_q  <= retired_d;
        end
    end

    assign bus.imem_req = imem_req;
    assign bus.ir_we    = ir_we;
    assign bus.pc_we    = pc_we;
    assign bus.pc_sel   = pc_sel;
    assign bus.alu_op   = alu_op;
    assign bus.alu_asel = alu_asel;
    assign bus.alu_bsel = alu_bsel;
    assign bus.ext_sign = ext_sign;
    assign bus.rf_we    = rf_we;
    assign bus.rf_wsel  = rf_wsel;
    assign bus.wd_sel   = wd_sel;
    assign bus.dmem_req = dmem_req;
    assign bus.dmem_we  = dmem_we;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;
    assign bus.timeout  = timeout_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. Each instruction is walked through
// its phases by a transaction-level reference: expected controls per cycle are
// derived from the instruction number, the zero flag and the chosen memory
// wait counts. Ready/zero lines carry random noise where they must be ignored.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.WAIT_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Expected values
    logic [2:0]  e_state;
    logic        e_imem_req, e_ir_we, e_pc_we, e_rf_we, e_dmem_req, e_dmem_we;
    logic [1:0]  e_pc_sel, e_rf_wsel, e_wd_sel;
    logic [3:0]  e_alu_op;
    logic        e_asel, e_bsel, e_ext;
    logic        e_illegal, e_timeout;
    logic [31:0] e_retired;
    int          cur_op;
    bit          strict;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_alu_op(input int op);
        case (op)
            0, 17:      return 4'd1;
            2, 24, 25:  return 4'd2;
            3:          return 4'd3;
            4, 19:      return 4'd4;
            5, 20:      return 4'd5;
            6, 21:      return 4'd6;
            7:          return 4'd7;
            8, 26:      return 4'd8;
            9, 27:      return 4'd9;
            10, 13:     return 4'd10;
            11, 14:     return 4'd11;
            12, 15:     return 4'd12;
            28:         return 4'd13;
            default:    return 4'd0;   // addu, addiu, lw, sw
        endcase
    endfunction

    function automatic logic [23:0] obs_vec();
        return {bus.state, bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel,
                bus.alu_op, bus.alu_asel, bus.alu_bsel, bus.ext_sign,
                bus.rf_we, bus.rf_wsel, bus.wd_sel, bus.dmem_req, bus.dmem_we,
                bus.illegal, bus.timeout};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {e_state, e_imem_req, e_ir_we, e_pc_we, e_pc_sel,
                e_alu_op, e_asel, e_bsel, e_ext,
                e_rf_we, e_rf_wsel, e_wd_sel, e_dmem_req, e_dmem_we,
                e_illegal, e_timeout};
    endfunction

    // Fields the specification leaves open in a given cycle are not compared.
    function automatic logic [23:0] care_mask();
        logic [23:0] m;
        m = '1;
        if (!strict) begin
            if (!(e_state == 3'd2 || e_state == 3'd3 || e_state == 3'd4)) m[15:9] = '0;
            if (cur_op == 16 || cur_op == 29 || cur_op == 30) m[15:12] = '0;
            if (!e_pc_we)    m[17:16] = '0;
            if (!e_rf_we)    m[7:4]   = '0;
            if (!e_dmem_req) m[2]     = 1'b0;
        end
        return m;
    endfunction

    task automatic clear_exp();
        e_imem_req = 0; e_ir_we = 0; e_pc_we = 0; e_pc_sel = 0;
        e_alu_op = 0; e_asel = 0; e_bsel = 0; e_ext = 0;
        e_rf_we = 0; e_rf_wsel = 0; e_wd_sel = 0; e_dmem_req = 0; e_dmem_we = 0;
    endtask

    task automatic set_alu(input int op);
        e_alu_op = ref_alu_op(op);
        e_asel   = (op >= 10 && op <= 12);
        e_bsel   = (op >= 17 && op <= 28 && op != 24 && op != 25);
        e_ext    = !(op == 19 || op == 20 || op == 21 || op == 28);
    endtask

    task automatic noise();
        bus.imem_ready = 1'($urandom_range(0, 1));
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.zero       = 1'($urandom_range(0, 1));
    endtask

    // Compare one cycle, then account for the retire it causes.
    task automatic end_cycle(input string tag);
        logic [23:0] m;
        #1;
        m = care_mask();
        check_eq({tag, "/ctl"}, 64'(obs_vec() & m), 64'(exp_vec() & m));
        check_eq({tag, "/retired"}, 64'(bus.retired), 64'(e_retired));
        if (e_pc_we) e_retired = e_retired + 32'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        noise();
        clear_exp();
        e_state = 0; e_illegal = 0; e_timeout = 0; e_retired = 0;
        strict = 1;
        end_cycle("reset");
        @(negedge clk);
        noise();
        bus.inst_onehot = $urandom();
        end_cycle("reset_hold");
        strict = 0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            noise();
            bus.inst_onehot = $urandom();
            clear_exp();
            e_state = 3'd7;
            end_cycle("halt");
        end
    endtask

    // status: 0 retired normally, 1 halted, 2 aborted by reset in MEM
    task automatic run_instr(input logic [31:0] inst, input int iwait, input int dwait,
                             input int zf, input bit abort_mem, output int status);
        int  op;
        int  nxt;
        bit  done;
        status = 0;
        op = 0;
        for (int b = 0; b < 32; b++) if (inst[b]) op = b;
        cur_op = op;

        done = 0;
        for (int c = 0; !done; c++) begin
            @(negedge clk);
            rst = 1'b0;
            noise();
            bus.inst_onehot = $urandom();
            bus.imem_ready  = (c == iwait);
            clear_exp();
            e_state = 0; e_imem_req = 1; e_ir_we = (c == iwait);
            end_cycle("fetch");
            if (c == iwait) begin
                done = 1;
            end else if (c == LIMIT - 1) begin
                e_timeout = 1; e_state = 3'd7; status = 1; done = 1;
            end
        end
        if (status != 0) return;

        @(negedge clk);
        noise();
        bus.inst_onehot = inst;
        clear_exp();
        e_state = 3'd1;
        end_cycle("decode");
        if ($countones(inst) != 1 || inst[31]) begin
            e_illegal = 1; e_state = 3'd7; status = 1;
            return;
        end

        @(negedge clk);
        noise();
        if (zf >= 0) bus.zero = zf[0];
        clear_exp();
        e_state = 3'd2;
        set_alu(op);
        nxt = 4;
        case (op)
            24, 25: begin
                e_pc_we  = 1;
                e_pc_sel = ((op == 24 && bus.zero) || (op == 25 && !bus.zero)) ? 2'd1 : 2'd0;
                nxt = 0;
            end
            29: begin e_pc_we = 1; e_pc_sel = 2'd2; nxt = 0; end
            16: begin e_pc_we = 1; e_pc_sel = 2'd3; nxt = 0; end
            30: begin
                e_pc_we = 1; e_pc_sel = 2'd2;
                e_rf_we = 1; e_rf_wsel = 2'd2; e_wd_sel = 2'd2;
                nxt = 0;
            end
            22, 23: nxt = 3;
            default: nxt = 4;
        endcase
        end_cycle("exec");
        if (nxt == 0) return;

        if (nxt == 3) begin
            done = 0;
            for (int c = 0; !done; c++) begin
                @(negedge clk);
                noise();
                bus.dmem_ready = abort_mem ? 1'b0 : (c == dwait);
                clear_exp();
                e_state = 3'd3;
                set_alu(op);
                e_dmem_req = 1;
                e_dmem_we  = (op == 23);
                if (bus.dmem_ready && op == 23) begin
                    e_pc_we = 1; e_pc_sel = 2'd0;
                end
                end_cycle("mem");
                if (abort_mem) begin
                    do_reset();
                    status = 2;
                    return;
                end
                if (bus.dmem_ready) begin
                    done = 1;
                    if (op == 23) return;
                end else if (c == LIMIT - 1) begin
                    e_timeout = 1; e_state = 3'd7; status = 1;
                    return;
                end
            end
        end

        @(negedge clk);
        noise();
        clear_exp();
        e_state = 3'd4;
        set_alu(op);
        e_rf_we = 1; e_pc_we = 1; e_pc_sel = 2'd0;
        e_rf_wsel = (op <= 15) ? 2'd0 : 2'd1;
        e_wd_sel  = (op == 22) ? 2'd1 : 2'd0;
        end_cycle("wb");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst = 1'b1;
        bus.inst_onehot = '0;
        bus.imem_ready = 0; bus.dmem_ready = 0; bus.zero = 0;
        cur_op = 0; strict = 0;
        e_illegal = 0; e_timeout = 0; e_retired = 0;
        do_reset();

        // Directed: addu at zero wait, lw with 3 data wait states,
        // beq taken / not taken, bne, jal, j, jr, sw.
        run_instr(32'h1 << 1,  0, 0, -1, 0, st);
        run_instr(32'h1 << 22, 0, 3, -1, 0, st);
        run_instr(32'h1 << 24, 0, 0,  1, 0, st);
        run_instr(32'h1 << 24, 0, 0,  0, 0, st);
        run_instr(32'h1 << 25, 1, 0,  0, 0, st);
        run_instr(32'h1 << 30, 2, 0, -1, 0, st);
        run_instr(32'h1 << 29, 0, 0, -1, 0, st);
        run_instr(32'h1 << 16, 0, 0, -1, 0, st);
        run_instr(32'h1 << 23, 0, 2, -1, 0, st);
        // Ready arriving on the last allowed wait cycle still completes.
        run_instr(32'h1 << 20, LIMIT - 1, 0, -1, 0, st);
        run_instr(32'h1 << 22, 0, LIMIT - 1, -1, 0, st);

        // Random legal instruction stream
        for (int n = 0; n < 150; n++) begin
            int op;
            op = $urandom_range(0, 30);
            run_instr(32'h1 << op, $urandom_range(0, LIMIT - 1),
                      $urandom_range(0, LIMIT - 1), -1, 0, st);
        end

        // Illegal encodings halt and stay halted until reset.
        run_instr(32'h0000_0000, 0, 0, -1, 0, st);
        check_eq("illegal_zero_status", 64'(st), 64'd1);
        halt_cycles(10);
        do_reset();
        run_instr(32'h0000_0003, 1, 0, -1, 0, st);
        halt_cycles(10);
        do_reset();
        run_instr(32'h8000_0000, 0, 0, -1, 0, st);
        halt_cycles(4);
        do_reset();
        run_instr(32'h1 << 5, 0, 0, -1, 0, st);

        // Instruction fetch timeout
        run_instr(32'h1 << 1, LIMIT, 0, -1, 0, st);
        check_eq("imem_timeout_status", 64'(st), 64'd1);
        halt_cycles(6);
        do_reset();

        // Data access timeout: no register or PC write may follow.
        run_instr(32'h1 << 0, 0, 0, -1, 0, st);
        run_instr(32'h1 << 22, 0, LIMIT, -1, 0, st);
        halt_cycles(6);
        do_reset();

        // Reset in the middle of a store aborts it with no write strobes.
        run_instr(32'h1 << 23, 0, 0, -1, 1, st);
        check_eq("abort_status", 64'(st), 64'd2);
        run_instr(32'h1 << 18, 0, 0, -1, 0, st);
        run_instr(32'h1 << 28, 1, 0, -1, 0, st);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the CPU datapath.
- Consumes the 32-bit one-hot instruction vector from the instruction decoder and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives PC, IR, register-file, ALU, extender and data-memory controls, and handshakes with instruction and data memory.
- Retires one instruction per 3–5 cycles, plus memory wait states.

Parameters:
- WAIT_LIMIT, 255: maximum cycles spent waiting on imem_ready/dmem_ready before a timeout halt.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- inst_onehot  in  32  decoded instruction, bit map below; assumed valid only after IR load
- zero  in  1  ALU zero flag
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- pc_we  out  1  PC write strobe
- pc_sel  out  2  PC source: 0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs
- alu_op  out  4  ALU operation code
- alu_asel  out  1  ALU A operand: 0 = rs, 1 = shamt
- alu_bsel  out  1  ALU B operand: 0 = rt, 1 = extended immediate
- ext_sign  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- rf_we  out  1  register-file write strobe
- rf_wsel  out  2  destination register: 0 = rd, 1 = rt, 2 = $31
- wd_sel  out  2  write-data source: 0 = ALU, 1 = dmem, 2 = pc+4
- dmem_req  out  1  data-memory request
- dmem_we  out  1  data-memory write (with dmem_req)
- state  out  3  current state code
- illegal  out  1  sticky illegal-instruction flag
- timeout  out  1  sticky memory-timeout flag
- retired  out  32  retired-instruction count

Behaviour:
- Bit map of inst_onehot: 0 add, 1 addu, 2 subu, 3 sub, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sll, 11 srl, 12 sra, 13 sllv, 14 srlv, 15 srav, 16 jr, 17 addi, 18 addiu, 19 andi, 20 ori, 21 xori, 22 lw, 23 sw, 24 beq, 25 bne, 26 slti, 27 sltiu, 28 lui, 29 j, 30 jal. Bit 31 is unused.
- State codes: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 7.
- Reset (async):
  - state = FETCH; retired = 0; wait counter = 0; illegal = 0; timeout = 0.
  - All strobes are 0 and all selects are 0 while rst is high.
- FETCH:
  - imem_req = 1.
  - If imem_ready is sampled high: ir_we = 1 (Mealy) and next state = DECODE.
  - Otherwise the wait counter increments.
- DECODE (1 cycle):
  - If inst_onehot is zero, has more than one bit set, has bit 31 set, or contains X: illegal <= 1, next state = HALT.
  - Otherwise next state = EXEC.
- EXEC: alu_op, alu_asel, alu_bsel and ext_sign are held valid from EXEC through WB.
  - beq/bne: pc_we = 1; pc_sel = 1 if (beq & zero) | (bne & ~zero), else 0; next state = FETCH.
  - j: pc_we = 1, pc_sel = 2, next state = FETCH.
  - jr: pc_we = 1, pc_sel = 3, next state = FETCH.
  - jal: pc_we = 1, pc_sel = 2, rf_we = 1, rf_wsel = 2, wd_sel = 2 in the same cycle; next state = FETCH.
  - lw/sw: next state = MEM.
  - All other instructions: next state = WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for sw only.
  - On dmem_ready: sw does pc_we = 1, pc_sel = 0, next state = FETCH; lw goes to WB.
  - While dmem_ready is low, stay in MEM and increment the wait counter.
- WB:
  - rf_we = 1 and pc_we = 1 with pc_sel = 0; next state = FETCH.
  - rf_wsel = 0 for R-type, 1 for I-type and lw.
  - wd_sel = 1 for lw, 0 otherwise.
- alu_op codes:
  - 0 ADDU: addu, addiu, lw, sw
  - 1 ADD: add, addi
  - 2 SUBU: subu, beq, bne
  - 3 SUB
  - 4 AND: and, andi
  - 5 OR: or, ori
  - 6 XOR: xor, xori
  - 7 NOR
  - 8 SLT: slt, slti
  - 9 SLTU: sltu, sltiu
  - 10 SLL: sll, sllv
  - 11 SRL: srl, srlv
  - 12 SRA: sra, srav
  - 13 LUI
- Operand and extension selects:
  - alu_asel = 1 only for sll, srl, sra.
  - alu_bsel = 1 for all I-type except beq/bne.
  - ext_sign = 0 for andi, ori, xori, lui; 1 otherwise.
- Wait counter:
  - Clears on every state change.
  - If it reaches WAIT_LIMIT while waiting in FETCH or MEM: timeout <= 1, next state = HALT. No pc_we or rf_we is issued.
  - A ready signal sampled on the same edge that the counter hits WAIT_LIMIT wins: the access completes and no timeout is raised.
- Handshakes:
  - Requests stay high until ready is sampled.
  - Ready in the first request cycle is legal, giving zero wait states.
  - Ready while no request is asserted is ignored.
- retired:
  - Increments by 1 on every cycle with pc_we = 1, and wraps 0xFFFFFFFF -> 0.
  - HALT stops it.
- HALT:
  - Absorbing state; all strobes are 0.
  - Flags stay set; only rst exits.
- Reset asserted mid-instruction aborts it immediately: no partial rf_we or dmem_we after the rst edge.

Test Plan:
- addu, imem_ready and dmem_ready always 1 -> states 0,1,2,4,0; alu_op = 0; rf_we and pc_we high in WB only; retired = 1 after 4 cycles.
- lw with dmem_ready delayed 3 cycles -> MEM lasts 4 cycles with dmem_req = 1 and dmem_we = 0; WB has wd_sel = 1 and rf_wsel = 1; retired = 1.
- beq with zero = 1, then zero = 0 -> EXEC shows pc_sel = 1, then pc_sel = 0; both take 3 cycles; rf_we is never asserted.
- jal -> in EXEC: pc_sel = 2, rf_we = 1, rf_wsel = 2, wd_sel = 2; next state = FETCH.
- inst_onehot = 0 (and separately 0x00000003) -> DECODE goes to HALT; illegal = 1; all strobes 0 for 10 further cycles; rst then returns to FETCH with illegal = 0.
- With WAIT_LIMIT = 4, imem_ready held low -> timeout = 1, state = 7 after 4 wait cycles; a rerun with ready arriving on cycle 4 -> no timeout, state goes to DECODE.
